// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op_code encodings
//   - FSM state enum (hilo_state_e) and accumulate mode enum (acc_mode_e)
//   - 64-bit result type and a sign-aware 32x32->64 multiply helper
package hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } hilo_state_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_mode_e;

  typedef logic [63:0] result_t;

  // Extending both operands to 64 bits (sign or zero) and keeping the low
  // 64 bits of the product gives the correct signed or unsigned result.
  function automatic result_t mul64(input logic [31:0] a, input logic [31:0] b,
                                    input logic is_signed);
    result_t ea;
    result_t eb;
    ea = {{32{is_signed & a[31]}}, a};
    eb = {{32{is_signed & b[31]}}, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/hilo_if.sv
// hilo_if: execute-stage port bundle of the HI/LO unit.
//   master (execute stage): op_valid, op_code, op_a, op_b, rd_req, rd_sel
//   slave  (hilo_unit)    : op_ready, rd_data, rd_stall, busy, div_zero, dbg_state
//
// Handshake: an operation transfers on a rising clock edge where
// op_valid && op_ready. Once op_valid is raised the master holds op_valid,
// op_code, op_a and op_b stable until that edge. op_ready never depends on
// op_valid. The read port has no handshake: rd_data always shows the current
// register, and rd_stall tells the master to retry while an operation runs.
interface hilo_if;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic        busy;
  logic        div_zero;
  hilo_pkg::hilo_state_e dbg_state;

  modport master (
    output op_valid, op_code, op_a, op_b, rd_req, rd_sel,
    input  op_ready, rd_data, rd_stall, busy, div_zero, dbg_state
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, rd_req, rd_sel,
    output op_ready, rd_data, rd_stall, busy, div_zero, dbg_state
  );
endinterface

// File: rtl/hilo_div_iter.sv
// hilo_div_iter: 32-iteration restoring divider on unsigned magnitudes.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : loads dividend/divisor at the end of this cycle
//   dividend   : 32-bit unsigned dividend
//   divisor    : 32-bit unsigned divisor (nonzero; zero is handled upstream)
//   done       : high in the cycle whose clock edge completes iteration 32
//   quotient   : quotient bits, final after the done edge
//   remainder  : partial remainder, final after the done edge
module hilo_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic        run_q, run_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    // Quotient register doubles as the dividend shift register.
    shifted = {rem_q, quo_q[31]};
    if (start) begin
      run_d = 1'b1;
      cnt_d = 5'd0;
      quo_d = dividend;
      rem_d = 32'd0;
      dvs_d = divisor;
    end else if (run_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        // True difference is below the divisor, so 32-bit wrap is exact.
        rem_d = shifted[31:0] - dvs_q;
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= 5'd0;
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign done      = run_q && (cnt_q == 5'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: sequential HI/LO unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO, optional
// MADD/MADDU/MSUB/MSUBU) holding the architectural HI and LO registers.
//   MUL_STAGES : multiply latency in cycles (1..4)
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : hilo_if.slave -- op handshake, MFHI/MFLO read port, status
// Build option: define HILO_MADD_EN to enable the accumulate codes 8..11;
// without it those codes are NOPs and no accumulate adder exists.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic  clk,
  input  logic  rst,
  hilo_if.slave bus
);
  hilo_state_e state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  result_t     prod_q, prod_d;
  logic [2:0]  mul_cnt_q, mul_cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] dz_a_q, dz_a_d;
  logic        div_zero_q, div_zero_d;
`ifdef HILO_MADD_EN
  acc_mode_e   acc_q, acc_d;
`endif

  logic        accept;
  logic        signed_div;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;
  result_t     prod_now;
  result_t     mul_res;

  assign accept     = bus.op_valid && (state_q == ST_IDLE);
  assign signed_div = (bus.op_code == OP_DIV);
  assign a_neg      = signed_div & bus.op_a[31];
  assign b_neg      = signed_div & bus.op_b[31];
  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  assign mag_a      = a_neg ? (~bus.op_a + 32'd1) : bus.op_a;
  assign mag_b      = b_neg ? (~bus.op_b + 32'd1) : bus.op_b;
  assign prod_now   = mul64(bus.op_a, bus.op_b,
                            (bus.op_code == OP_MULT) || (bus.op_code == OP_MADD) ||
                            (bus.op_code == OP_MSUB));

`ifdef HILO_MADD_EN
  // HI/LO cannot change while in MUL, so accumulating at write time is safe.
  always_comb begin
    case (acc_q)
      ACC_ADD: mul_res = {hi_q, lo_q} + prod_q;
      ACC_SUB: mul_res = {hi_q, lo_q} - prod_q;
      default: mul_res = prod_q;
    endcase
  end
`else
  assign mul_res = prod_q;
`endif

  hilo_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    prod_d     = prod_q;
    mul_cnt_d  = mul_cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_d       = dz_q;
    dz_a_d     = dz_a_q;
    div_zero_d = 1'b0;
    div_start  = 1'b0;
`ifdef HILO_MADD_EN
    acc_d      = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op_code)
            OP_MULT, OP_MULTU: begin
`ifdef HILO_MADD_EN
              acc_d = ACC_NONE;
`endif
              if (MUL_STAGES == 1) begin
                {hi_d, lo_d} = prod_now;
              end else begin
                prod_d    = prod_now;
                mul_cnt_d = 3'(MUL_STAGES - 1);
                state_d   = ST_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              if (bus.op_b == 32'd0) begin
                dz_d       = 1'b1;
                dz_a_d     = bus.op_a;
                div_zero_d = 1'b1;
                state_d    = ST_FIX;
              end else begin
                dz_d      = 1'b0;
                div_start = 1'b1;
                q_neg_d   = a_neg ^ b_neg;
                r_neg_d   = a_neg;
                state_d   = ST_DIV;
              end
            end
            OP_MTHI: hi_d = bus.op_a;
            OP_MTLO: lo_d = bus.op_a;
`ifdef HILO_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              prod_d    = prod_now;
              acc_d     = ((bus.op_code == OP_MADD) || (bus.op_code == OP_MADDU)) ?
                          ACC_ADD : ACC_SUB;
              // One extra cycle for the accumulate step.
              mul_cnt_d = 3'(MUL_STAGES);
              state_d   = ST_MUL;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == 3'd1) begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_IDLE;
        end else begin
          mul_cnt_d = mul_cnt_q - 3'd1;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = dz_a_q;
        end else begin
          lo_d = q_neg_q ? (~div_quo + 32'd1) : div_quo;
          hi_d = r_neg_q ? (~div_rem + 32'd1) : div_rem;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      prod_q     <= '0;
      mul_cnt_q  <= 3'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      dz_a_q     <= 32'd0;
      div_zero_q <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q      <= ACC_NONE;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      prod_q     <= prod_d;
      mul_cnt_q  <= mul_cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_q       <= dz_d;
      dz_a_q     <= dz_a_d;
      div_zero_q <= div_zero_d;
`ifdef HILO_MADD_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign bus.op_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rd_stall  = bus.rd_req && (state_q != ST_IDLE);
  assign bus.rd_data   = bus.rd_sel ? hi_q : lo_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: self-checking bench for hilo_unit (vector table, directed
// multi-cycle sequences, randomized operations against a reference model).
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int MUL_STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hilo_if bus ();

  hilo_unit #(.MUL_STAGES(MUL_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] model_hl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one operation on {HI,LO}.
  function automatic logic [63:0] ref_op(input logic [3:0] code, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     sp, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sp = sa * sb;
    up = ua * ub;
    case (code)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd5: return {a, hl[31:0]};
      4'd6: return {hl[63:32], a};
`ifdef HILO_MADD_EN
      4'd8:  return hl + sp;
      4'd9:  return hl + up;
      4'd10: return hl - sp;
      4'd11: return hl - up;
`endif
      default: return hl;
    endcase
  endfunction

  function automatic int exp_busy(input logic [3:0] code, input logic [31:0] b);
    case (code)
      4'd1, 4'd2: return MUL_STAGES - 1;
      4'd3, 4'd4: return (b == 32'd0) ? 1 : 33;
`ifdef HILO_MADD_EN
      4'd8, 4'd9, 4'd10, 4'd11: return MUL_STAGES;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic int exp_dz(input logic [3:0] code, input logic [31:0] b);
    return ((code == 4'd3 || code == 4'd4) && b == 32'd0) ? 1 : 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.op_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("issue_ready", {63'd0, bus.op_ready}, 64'd1);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 4'd0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
  endtask

  // Counts busy cycles after the accept edge; records div_zero pulses and
  // the cycle index (1 = first cycle after accept) of the last one seen.
  task automatic wait_idle(output int busy_cnt, output int dz_cnt, output int dz_k);
    busy_cnt = 0;
    dz_cnt   = 0;
    dz_k     = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.div_zero) begin
        dz_cnt++;
        dz_k = k;
      end
      if (!bus.busy) break;
      busy_cnt++;
    end
  endtask

  task automatic read_hilo(output logic [63:0] v);
    bus.rd_sel = 1'b1;
    #1 v[63:32] = bus.rd_data;
    bus.rd_sel = 1'b0;
    #1 v[31:0] = bus.rd_data;
  endtask

  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] act, output int bc, output int dc, output int dk);
    issue(code, a, b);
    wait_idle(bc, dc, dk);
    read_hilo(act);
  endtask

  task automatic run_checked(input string name, input logic [3:0] code,
                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] act;
    int bc, dc, dk;
    exp_q.push_back(ref_op(code, a, b, model_hl));
    model_hl = exp_q[$];
    run_op(code, a, b, act, bc, dc, dk);
    check({name, "_hilo"}, act, exp_q.pop_front());
    check({name, "_busy"}, 64'(bc), 64'(exp_busy(code, b)));
    check({name, "_dz"}, 64'(dc), 64'(exp_dz(code, b)));
    if (dc != 0) check({name, "_dz_cycle"}, 64'(dk), 64'd1);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 50));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
    int          exp_dz;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [63:0] act;
    int bc, dc, dk;
    int stall_cnt;
    logic [31:0] last_data, fin_data;

    tbl[0]  = '{4'd1,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STAGES-1, 0};
    tbl[1]  = '{4'd2,  32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, MUL_STAGES-1, 0};
    tbl[2]  = '{4'd3,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0};
    tbl[3]  = '{4'd4,  32'd100,       32'd7,        32'd2,         32'd14,        33, 0};
    tbl[4]  = '{4'd4,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1,  1};
    tbl[5]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33, 0};
    tbl[6]  = '{4'd3,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33, 0};
    tbl[7]  = '{4'd3,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1,  1};
    tbl[8]  = '{4'd5,  32'hDEAD_BEEF, 32'd3,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 0,  0};
    tbl[9]  = '{4'd6,  32'h0000_1234, 32'd3,        32'hDEAD_BEEF, 32'h0000_1234, 0,  0};
    tbl[10] = '{4'd0,  32'd5,         32'd6,        32'hDEAD_BEEF, 32'h0000_1234, 0,  0};
    tbl[11] = '{4'd7,  32'd99,        32'd1,        32'hDEAD_BEEF, 32'h0000_1234, 0,  0};
    tbl[12] = '{4'd1,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        MUL_STAGES-1, 0};
    tbl[13] = '{4'd15, 32'd1,         32'd1,        32'h4000_0000, 32'd0,         0,  0};
    tbl[14] = '{4'd4,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33, 0};
    tbl[15] = '{4'd3,  32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 33, 0};
    tbl[16] = '{4'd12, 32'd4,         32'd0,        32'd2,         32'hFFFF_FFF2, 0,  0};

    bus.op_valid = 1'b0;
    bus.op_code  = 4'd0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.rd_req = 1'b1;
    #1;
    check("rst_op_ready", {63'd0, bus.op_ready}, 64'd1);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_div_zero", {63'd0, bus.div_zero}, 64'd0);
    check("rst_rd_stall", {63'd0, bus.rd_stall}, 64'd0);
    bus.rd_req = 1'b0;
    read_hilo(act);
    check("rst_hilo", act, 64'd0);
    rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 17; i++) begin
      run_op(tbl[i].code, tbl[i].a, tbl[i].b, act, bc, dc, dk);
      check($sformatf("tbl%0d_hilo", i), act, {tbl[i].exp_hi, tbl[i].exp_lo});
      check($sformatf("tbl%0d_busy", i), 64'(bc), 64'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_dz", i), 64'(dc), 64'(tbl[i].exp_dz));
      if (tbl[i].exp_dz != 0) check($sformatf("tbl%0d_dz_cycle", i), 64'(dk), 64'd1);
    end

    // ---- read stalled during DIVU, new value visible right after ----
    run_op(4'd6, 32'h55, 32'd0, act, bc, dc, dk);
    check("stall_pre_lo", act, {32'd2, 32'h55});
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b0;
    issue(4'd4, 32'd100, 32'd7);
    stall_cnt = 0;
    last_data = 32'd0;
    fin_data  = 32'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (bus.rd_stall) begin
        stall_cnt++;
        last_data = bus.rd_data;
      end else begin
        fin_data = bus.rd_data;
        break;
      end
    end
    check("stall_cycles", 64'(stall_cnt), 64'd33);
    check("stall_old_at_write", {32'd0, last_data}, 64'h55);
    check("stall_read_after", {32'd0, fin_data}, 64'd14);
    bus.rd_req = 1'b0;

    // ---- MTLO then immediate read; same-cycle read returns old ----
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'd6;
    bus.op_a     = 32'h1234;
    bus.rd_sel   = 1'b0;
    #1 check("mtlo_same_cycle_old", {32'd0, bus.rd_data}, 64'd14);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 4'd0;
    bus.op_a     = 32'd0;
    @(negedge clk);
    #1 check("mtlo_next_read", {32'd0, bus.rd_data}, 64'h1234);
    check("mtlo_not_busy", {63'd0, bus.busy}, 64'd0);

    // ---- accumulate codes ----
    run_op(4'd5, 32'd0, 32'd0, act, bc, dc, dk);
    run_op(4'd6, 32'd5, 32'd0, act, bc, dc, dk);
    check("madd_setup", act, 64'd5);
    run_op(4'd8, 32'd3, 32'd4, act, bc, dc, dk);
`ifdef HILO_MADD_EN
    check("madd_hilo", act, 64'h11);
    check("madd_busy", 64'(bc), 64'(MUL_STAGES));
    run_op(4'd11, 32'd1, 32'h12, act, bc, dc, dk);
    check("msubu_hilo", act, 64'hFFFF_FFFF_FFFF_FFFF);
    check("msubu_busy", 64'(bc), 64'(MUL_STAGES));
`else
    check("madd_nop_hilo", act, 64'd5);
    check("madd_nop_busy", 64'(bc), 64'd0);
`endif

    // ---- reset in the middle of a DIV ----
    run_op(4'd5, 32'd9, 32'd0, act, bc, dc, dk);
    issue(4'd3, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    check("rst_mid_pre_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_ready", {63'd0, bus.op_ready}, 64'd1);
    read_hilo(act);
    check("rst_mid_hilo", act, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_hl = 64'd0;
    run_checked("post_rst_mult", 4'd1, 32'd3, 32'd5);

    // ---- randomized operations against the model ----
    for (int i = 0; i < 40; i++) begin
      logic [3:0] code;
      code = 4'($urandom_range(0, 11));
      run_checked($sformatf("rnd%0d_op%0d", i, code), code, rand_opnd(), rand_opnd());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
